// File: rtl/udp_arb_pkg.sv
// Purpose : shared types and constants for the UDP TX round-robin arbiter.
//   arb_state_t - arbiter FSM states (IDLE arbitrates, BUSY forwards a packet)
//   udp_meta_t  - per-packet UDP metadata {remote ip, remote port, local port}
package udp_arb_pkg;

  localparam int IP_W   = 32;
  localparam int PORT_W = 16;
  localparam int META_W = IP_W + 2 * PORT_W;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [IP_W-1:0]   ip;
    logic [PORT_W-1:0] rport;
    logic [PORT_W-1:0] lport;
  } udp_meta_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Purpose : combinational round-robin pick. Returns the first asserted
//           request found by searching upward from i_last+1, wrapping at N.
// Ports   : i_req  [N]          request vector
//           i_last [$clog2(N)]  index granted most recently
//           o_any               at least one request is set
//           o_idx  [$clog2(N)]  chosen index (0 when o_any is low)
module rr_priority_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last,
  output logic                 o_any,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int LW = $clog2(N);

  int            w_sum;
  logic [LW-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit wins by being
  // written last.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_sum  = 0;
    w_cand = '0;
    for (int i = N; i >= 1; i--) begin
      w_sum  = int'(i_last) + i;
      w_cand = LW'(w_sum % N);
      if (i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/udp_tx_rr_arbiter.sv
// Purpose : packet-atomic round-robin arbiter merging NUM_REQ UDP TX
//           AXI-streams (data + metadata) onto one stream. A grant is held
//           from arbitration until the TLAST handshake, then one IDLE cycle
//           re-arbitrates.
// Ports   : i_clk, i_aresetn (sync, active-low)
//           i_req_TVALID/TDATA/TKEEP/TLAST, i_req_remote_ip/remote_port/
//           local_port : packed per-requester inputs, requester r at slot r
//           o_req_TREADY : per-requester ready, only the granted bit can be 1
//           o_output_TVALID/TDATA/TKEEP/TLAST, i_output_TREADY : merged stream
//           o_remote_ip_tx/o_remote_port_tx/o_local_port_tx : metadata latched
//           at grant;  o_grant_id : current or most recent grant
//           o_pkt_count [NUM_REQ*32] : per-requester packet counters, present
//           only when ARB_STATS_EN is defined
// Handshake: a beat transfers on a rising edge where VALID and READY are both
//           high; VALID never waits for READY, and while BUSY the granted
//           requester's VALID and the downstream READY pass straight through.
module udp_tx_rr_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 512
) (
  input  logic                              i_clk,
  input  logic                              i_aresetn,
  input  logic [NUM_REQ-1:0]                i_req_TVALID,
  output logic [NUM_REQ-1:0]                o_req_TREADY,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     i_req_TDATA,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   i_req_TKEEP,
  input  logic [NUM_REQ-1:0]                i_req_TLAST,
  input  logic [NUM_REQ*32-1:0]             i_req_remote_ip,
  input  logic [NUM_REQ*16-1:0]             i_req_remote_port,
  input  logic [NUM_REQ*16-1:0]             i_req_local_port,
  output logic                              o_output_TVALID,
  input  logic                              i_output_TREADY,
  output logic [DATA_WIDTH-1:0]             o_output_TDATA,
  output logic [DATA_WIDTH/8-1:0]           o_output_TKEEP,
  output logic                              o_output_TLAST,
  output logic [31:0]                       o_remote_ip_tx,
  output logic [15:0]                       o_remote_port_tx,
  output logic [15:0]                       o_local_port_tx,
`ifdef ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]             o_pkt_count,
`endif
  output logic [$clog2(NUM_REQ)-1:0]        o_grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int KW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [KW-1:0]         w_keep [NUM_REQ];
  udp_meta_t             w_meta [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_data[g] = i_req_TDATA[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_keep[g] = i_req_TKEEP[g*KW +: KW];
    assign w_meta[g] = {i_req_remote_ip[g*IP_W +: IP_W],
                        i_req_remote_port[g*PORT_W +: PORT_W],
                        i_req_local_port[g*PORT_W +: PORT_W]};
  end

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;
  udp_meta_t     r_meta;
  logic          w_pick_any;
  logic [GW-1:0] w_pick_idx;
  logic          w_last_hs;

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .i_req  (i_req_TVALID),
    .i_last (r_last),
    .o_any  (w_pick_any),
    .o_idx  (w_pick_idx)
  );

  // Final beat of the granted packet is accepted downstream.
  assign w_last_hs = (r_state == BUSY) & i_req_TVALID[r_grant] &
                     i_output_TREADY & i_req_TLAST[r_grant];

  always_comb begin
    w_state_nxt     = r_state;
    o_output_TVALID = 1'b0;
    o_req_TREADY    = '0;
    o_output_TDATA  = '0;
    o_output_TKEEP  = '0;
    o_output_TLAST  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) w_state_nxt = BUSY;
      end
      BUSY: begin
        o_output_TVALID       = i_req_TVALID[r_grant];
        o_req_TREADY[r_grant] = i_output_TREADY;
        o_output_TDATA        = w_data[r_grant];
        o_output_TKEEP        = w_keep[r_grant];
        o_output_TLAST        = i_req_TLAST[r_grant];
        if (w_last_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_last resets to NUM_REQ-1 so that requester 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(NUM_REQ - 1);
      r_meta  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_any) begin
        r_grant <= w_pick_idx;
        r_meta  <= w_meta[w_pick_idx];
      end
      if (w_last_hs) r_last <= r_grant;
    end
  end

  assign o_remote_ip_tx   = r_meta.ip;
  assign o_remote_port_tx = r_meta.rport;
  assign o_local_port_tx  = r_meta.lport;
  assign o_grant_id       = r_grant;

`ifdef ARB_STATS_EN
  logic [31:0] r_pkt_count [NUM_REQ];

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!i_aresetn) begin
        r_pkt_count[r] <= '0;
      end else if (w_last_hs && r_grant == GW'(r)) begin
        r_pkt_count[r] <= r_pkt_count[r] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    assign o_pkt_count[g*32 +: 32] = r_pkt_count[g];
  end
`endif

endmodule

// File: tb/tb_udp_tx_rr_arbiter.sv
`timescale 1ns/1ps
module tb_udp_tx_rr_arbiter;
  import udp_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DW      = 512;
  localparam int KW      = DW / 8;
  localparam int GW      = $clog2(NUM_REQ);
  localparam int EXP_W   = GW + 1 + META_W + KW + DW;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_aresetn = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [NUM_REQ-1:0]      i_req_TVALID = '0;
  logic [NUM_REQ-1:0]      o_req_TREADY;
  logic [NUM_REQ*DW-1:0]   i_req_TDATA = '0;
  logic [NUM_REQ*KW-1:0]   i_req_TKEEP = '0;
  logic [NUM_REQ-1:0]      i_req_TLAST = '0;
  logic [NUM_REQ*32-1:0]   i_req_remote_ip = '0;
  logic [NUM_REQ*16-1:0]   i_req_remote_port = '0;
  logic [NUM_REQ*16-1:0]   i_req_local_port = '0;
  logic                    o_output_TVALID;
  logic                    i_output_TREADY = 1'b0;
  logic [DW-1:0]           o_output_TDATA;
  logic [KW-1:0]           o_output_TKEEP;
  logic                    o_output_TLAST;
  logic [31:0]             o_remote_ip_tx;
  logic [15:0]             o_remote_port_tx;
  logic [15:0]             o_local_port_tx;
  logic [GW-1:0]           o_grant_id;
`ifdef ARB_STATS_EN
  logic [NUM_REQ*32-1:0]   o_pkt_count;
`endif

  udp_tx_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk             (i_clk),
    .i_aresetn         (i_aresetn),
    .i_req_TVALID      (i_req_TVALID),
    .o_req_TREADY      (o_req_TREADY),
    .i_req_TDATA       (i_req_TDATA),
    .i_req_TKEEP       (i_req_TKEEP),
    .i_req_TLAST       (i_req_TLAST),
    .i_req_remote_ip   (i_req_remote_ip),
    .i_req_remote_port (i_req_remote_port),
    .i_req_local_port  (i_req_local_port),
    .o_output_TVALID   (o_output_TVALID),
    .i_output_TREADY   (i_output_TREADY),
    .o_output_TDATA    (o_output_TDATA),
    .o_output_TKEEP    (o_output_TKEEP),
    .o_output_TLAST    (o_output_TLAST),
    .o_remote_ip_tx    (o_remote_ip_tx),
    .o_remote_port_tx  (o_remote_port_tx),
    .o_local_port_tx   (o_local_port_tx),
`ifdef ARB_STATS_EN
    .o_pkt_count       (o_pkt_count),
`endif
    .o_grant_id        (o_grant_id)
  );

  // ---------------- sources, model, scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [31:0]   ip;
    logic [15:0]   rport;
    logic [15:0]   lport;
    int            gap;   // idle cycles the source inserts before this beat
  } beat_t;

  beat_t            src_q [NUM_REQ][$];
  logic [EXP_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               m_last;
  int               m_cnt [NUM_REQ];
  int               n_checks = 0;
  int               n_fail = 0;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic add_packet(input int r, input int len, input bit gaps,
                            input logic [31:0] ip, input logic [31:0] ip_rest,
                            input logic [15:0] rp, input logic [15:0] lp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = rand_data();
      b.keep  = {$urandom, $urandom};
      b.last  = (i == len - 1);
      b.ip    = (i == 0) ? ip : ip_rest;
      b.rport = rp;
      b.lport = lp;
      b.gap   = (gaps && i > 0) ? int'($urandom_range(0, 2)) : 0;
      src_q[r].push_back(b);
    end
  endtask

  // Packet-level model: every queued packet is pending from the start, so
  // whole packets leave in round-robin order after m_last. Without stalls,
  // each packet takes one arbitration cycle plus one cycle per beat.
  task automatic plan_expected();
    int    pk [NUM_REQ];
    int    ptr [NUM_REQ];
    int    total, r, t;
    beat_t b, f;
    total = 0;
    t = 0;
    for (int q = 0; q < NUM_REQ; q++) begin
      pk[q] = 0;
      ptr[q] = 0;
      foreach (src_q[q][k]) if (src_q[q][k].last) pk[q]++;
      total += pk[q];
    end
    while (total > 0) begin
      r = m_last;
      do r = (r + 1) % NUM_REQ; while (pk[r] == 0);
      f = src_q[r][ptr[r]];
      do begin
        b = src_q[r][ptr[r]];
        ptr[r]++;
        t++;
        exp_q.push_back({GW'(r), b.last, f.ip, f.rport, f.lport, b.keep, b.data});
        exp_cyc_q.push_back(t);
      end while (!b.last);
      t++;
      pk[r]--;
      total--;
      m_last = r;
      m_cnt[r]++;
    end
  endtask

  task automatic check_stats(input string name);
`ifdef ARB_STATS_EN
    for (int r = 0; r < NUM_REQ; r++) begin
      n_checks++;
      if (o_pkt_count[r*32 +: 32] !== 32'(m_cnt[r])) begin
        n_fail++;
        $display("FAIL %s pkt_count[%0d]: got %0d expected %0d", name, r,
                 o_pkt_count[r*32 +: 32], m_cnt[r]);
      end
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // Called just after a rising edge with the DUT idle. mode: 0 READY always
  // high, 1 READY toggles 1,0,..., 2 READY random. exact: also check cycles.
  task automatic run_traffic(input string name, input int mode, input bit exact);
    int               cyc;
    int               hold [NUM_REQ];
    int               ecyc;
    logic [EXP_W-1:0] got, exp;
    cyc = 0;
    for (int r = 0; r < NUM_REQ; r++) hold[r] = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (src_q[r].size() > 0 && hold[r] == 0) begin
          i_req_TVALID[r]                = 1'b1;
          i_req_TDATA[r*DW +: DW]        = src_q[r][0].data;
          i_req_TKEEP[r*KW +: KW]        = src_q[r][0].keep;
          i_req_TLAST[r]                 = src_q[r][0].last;
          i_req_remote_ip[r*32 +: 32]    = src_q[r][0].ip;
          i_req_remote_port[r*16 +: 16]  = src_q[r][0].rport;
          i_req_local_port[r*16 +: 16]   = src_q[r][0].lport;
        end else begin
          i_req_TVALID[r] = 1'b0;
        end
      end
      case (mode)
        0:       i_output_TREADY = 1'b1;
        1:       i_output_TREADY = (cyc % 2 == 0);
        default: i_output_TREADY = 1'($urandom_range(0, 1));
      endcase
      @(negedge i_clk);
      n_checks++;
      if ($countones(o_req_TREADY) > 1 ||
          (o_req_TREADY & ~(NUM_REQ'(1) << o_grant_id)) != '0) begin
        n_fail++;
        $display("FAIL %s tready_granted_only: got %b grant %0d cycle %0d",
                 name, o_req_TREADY, o_grant_id, cyc);
      end
      if (o_output_TVALID && i_output_TREADY) begin
        got = {o_grant_id, o_output_TLAST, o_remote_ip_tx, o_remote_port_tx,
               o_local_port_tx, o_output_TKEEP, o_output_TDATA};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_beat: got beat from grant %0d, none expected", name, o_grant_id);
        end else begin
          exp  = exp_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL %s beat: got %h expected %h", name, got, exp);
          end
          if (exact) begin
            n_checks++;
            if (cyc != ecyc) begin
              n_fail++;
              $display("FAIL %s beat_cycle: got %0d expected %0d", name, cyc, ecyc);
            end
          end
        end
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        if (i_req_TVALID[r] && o_req_TREADY[r]) begin
          void'(src_q[r].pop_front());
          if (src_q[r].size() > 0) hold[r] = src_q[r][0].gap;
        end else if (!i_req_TVALID[r] && hold[r] > 0) begin
          hold[r]--;
        end
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_req_TVALID = '0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d beats outstanding, expected 0", name, exp_q.size());
    end
    exp_q.delete();
    exp_cyc_q.delete();
    for (int r = 0; r < NUM_REQ; r++) src_q[r].delete();
    check_stats(name);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DW-1:0] d0, d1;
    logic [DW+KW+86:0] rst_obs;
    i_aresetn       = 1'b0;
    i_req_TVALID    = '1;
    i_req_TLAST     = '1;
    i_req_TDATA     = {rand_data(), rand_data()};
    i_req_TKEEP     = '1;
    i_req_remote_ip = {32'd1, 32'd2};
    i_output_TREADY = 1'b1;
    repeat (10) begin
      @(posedge i_clk);
      @(negedge i_clk);
      rst_obs = {o_output_TVALID, o_req_TREADY, o_output_TLAST, o_remote_ip_tx,
                 o_remote_port_tx, o_local_port_tx, o_grant_id, o_output_TDATA, o_output_TKEEP};
      n_checks++;
      if (rst_obs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid=%b tready=%b ip=%h grant=%0d expected all zero",
                 o_output_TVALID, o_req_TREADY, o_remote_ip_tx, o_grant_id);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) m_cnt[r] = 0;
    check_stats("reset");
    @(posedge i_clk);
    #1;
    d0 = rand_data();
    d1 = rand_data();
    i_aresetn         = 1'b1;
    i_req_TDATA       = {d1, d0};
    i_req_remote_ip   = {32'd20000, 32'd15000};
    i_req_remote_port = {16'd2000, 16'd1000};
    i_req_local_port  = {16'd600, 16'd500};
    i_output_TREADY   = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if ({o_output_TVALID, o_grant_id, o_output_TDATA, o_remote_ip_tx} !==
        {1'b1, GW'(0), d0, 32'd15000}) begin
      n_fail++;
      $display("FAIL first_grant: got valid=%b grant=%0d ip=%0d expected valid=1 grant=0 ip=15000",
               o_output_TVALID, o_grant_id, o_remote_ip_tx);
    end
    n_checks++;
    if (o_req_TREADY !== 2'b00) begin
      n_fail++;
      $display("FAIL ready_blocked: got %b expected 00", o_req_TREADY);
    end
    i_output_TREADY = 1'b1;
    #1;
    n_checks++;
    if (o_req_TREADY !== 2'b01) begin
      n_fail++;
      $display("FAIL ready_granted: got %b expected 01", o_req_TREADY);
    end
    @(posedge i_clk);
    #1;
    i_req_TVALID = '0;
    m_last   = 0;
    m_cnt[0] = 1;
    @(negedge i_clk);
    n_checks++;
    if (o_output_TVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_last: got valid=%b expected 0", o_output_TVALID);
    end
    check_stats("reset_release");
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_single_beat_req1();
    beat_t b;
    b.data  = '0;
    b.data[DW-1 -: 8] = 8'h02;
    b.keep  = '1;
    b.last  = 1'b1;
    b.ip    = 32'd15000;
    b.rport = 16'd1000;
    b.lport = 16'd500;
    b.gap   = 0;
    src_q[1].push_back(b);
    plan_expected();
    run_traffic("single_beat_req1", 0, 1'b1);
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 3; k++) begin
      add_packet(0, 1, 1'b0, 32'd100 + k, 32'd100 + k, 16'd1, 16'd2);
      add_packet(1, 1, 1'b0, 32'd200 + k, 32'd200 + k, 16'd3, 16'd4);
    end
    plan_expected();
    run_traffic("round_robin", 0, 1'b1);
  endtask

  task automatic test_backpressure();
    add_packet(0, 4, 1'b0, 32'd15000, 32'd15000, 16'd1000, 16'd500);
    add_packet(1, 1, 1'b0, 32'd20000, 32'd20000, 16'd2000, 16'd600);
    plan_expected();
    run_traffic("backpressure", 1, 1'b0);
  endtask

  task automatic test_meta_hold();
    add_packet(0, 3, 1'b0, 32'd15000, 32'd10000, 16'd1000, 16'd500);
    plan_expected();
    run_traffic("meta_hold", 0, 1'b1);
  endtask

  task automatic test_reset_mid_packet();
    i_req_TVALID      = 2'b01;
    i_req_TLAST       = '0;
    i_req_TDATA[DW-1:0] = rand_data();
    i_req_remote_ip[31:0] = 32'd15000;
    i_output_TREADY   = 1'b1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    n_checks++;
    if (o_output_TVALID !== 1'b1 || o_grant_id !== GW'(0)) begin
      n_fail++;
      $display("FAIL midrst_beat1: got valid=%b grant=%0d expected 1 0", o_output_TVALID, o_grant_id);
    end
    @(posedge i_clk);
    #1;
    i_req_TDATA[DW-1:0] = rand_data();
    i_aresetn = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    m_last = NUM_REQ - 1;
    for (int r = 0; r < NUM_REQ; r++) m_cnt[r] = 0;
    n_checks++;
    if ({o_output_TVALID, o_req_TREADY, o_grant_id, o_remote_ip_tx} !== '0) begin
      n_fail++;
      $display("FAIL midrst_abort: got valid=%b tready=%b grant=%0d ip=%0d expected all zero",
               o_output_TVALID, o_req_TREADY, o_grant_id, o_remote_ip_tx);
    end
    check_stats("midrst");
    @(posedge i_clk);
    #1;
    i_aresetn    = 1'b1;
    i_req_TVALID = '0;
    add_packet(0, 2, 1'b0, 32'd15000, 32'd15000, 16'd1000, 16'd500);
    add_packet(1, 1, 1'b0, 32'd20000, 32'd20000, 16'd2000, 16'd600);
    plan_expected();
    run_traffic("after_midrst", 0, 1'b1);
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        repeat ($urandom_range(1, 3))
          add_packet(r, int'($urandom_range(1, 5)), 1'b1, $urandom, $urandom,
                     16'($urandom), 16'($urandom));
      end
      plan_expected();
      run_traffic("random", (round == 0) ? 0 : 2, 1'b0);
    end
  endtask

  initial begin
    m_last = NUM_REQ - 1;
    for (int r = 0; r < NUM_REQ; r++) m_cnt[r] = 0;
    test_reset();
    test_single_beat_req1();
    test_round_robin();
    test_backpressure();
    test_meta_hold();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
